// File: rtl/alien_sweep.sv
// Marching-alien motion engine: horizontal sweep between bounds, drop and speed-up at each edge.
// Coordinates, strobes and status outputs are all registered; freeze stalls everything but kill.
module alien_sweep #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_START  = 114,
    parameter int Y_START  = 15,
    parameter int X_MIN    = 114,
    parameter int X_MAX    = 122,
    parameter int STEP     = 1,
    parameter int DROP     = 4,
    parameter int Y_LIMIT  = 111,
    parameter int TICK_DIV = 833334,
    parameter int PER_INIT = 15,
    parameter int PER_MIN  = 3,
    parameter int SPEEDUP  = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic           freeze,
    input  logic           kill,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           dir,
    output logic           update,
    output logic           active,
    output logic           landed,
    output logic           dead
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(PER_INIT + 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(TICK_DIV - 1);
    localparam logic [X_W-1:0] X_RST   = X_W'(X_START);
    localparam logic [Y_W-1:0] Y_RST   = Y_W'(Y_START);
    localparam logic [PW-1:0]  P_RST   = PW'(PER_INIT);
    localparam logic [31:0]    P_FLOOR = 32'(PER_MIN + SPEEDUP);

    typedef enum logic [2:0] {
        IDLE, RIGHT, DROP_L, LEFT, DROP_R, LANDED, DEAD
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] fcnt;
    logic [PW-1:0] period;

    logic          running;
    logic          tick;
    logic          move;
    logic [X_W:0]  x_inc;
    logic          at_left;
    logic [Y_W:0]  y_drop;
    logic          will_land;
    logic [31:0]   period_w;
    logic [PW-1:0] period_next;

    assign running   = ((state == RIGHT) || (state == LEFT)) && !freeze;
    assign tick      = running && (tcnt == T_LAST);
    assign move      = tick && (fcnt == period - PW'(1));
    // Extra-bit arithmetic so bound checks never wrap at the coordinate edges.
    assign x_inc     = {1'b0, x} + (X_W+1)'(STEP);
    assign at_left   = {1'b0, x} < (X_W+1)'(X_MIN + STEP);
    assign y_drop    = {1'b0, y} + (Y_W+1)'(DROP);
    assign will_land = y_drop >= (Y_W+1)'(Y_LIMIT);
    assign period_w  = 32'(period);
    assign period_next = (period_w > P_FLOOR) ? PW'(period_w - 32'(SPEEDUP)) : PW'(PER_MIN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            x      <= X_RST;
            y      <= Y_RST;
            dir    <= 1'b1;
            period <= P_RST;
            tcnt   <= '0;
            fcnt   <= '0;
            update <= 1'b0;
            active <= 1'b0;
            landed <= 1'b0;
            dead   <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && !freeze) begin
                        state  <= RIGHT;
                        active <= 1'b1;
                        tcnt   <= '0;
                        fcnt   <= '0;
                    end
                end
                RIGHT, LEFT: begin
                    if (kill) begin
                        state  <= DEAD;
                        active <= 1'b0;
                        dead   <= 1'b1;
                    end else if (running) begin
                        if (tick) begin
                            tcnt <= '0;
                            fcnt <= move ? '0 : fcnt + PW'(1);
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                        // The edge-hitting move only switches state; the drop happens next cycle.
                        if (move) begin
                            if (state == RIGHT) begin
                                if (x_inc > (X_W+1)'(X_MAX)) begin
                                    state <= DROP_L;
                                end else begin
                                    x      <= x_inc[X_W-1:0];
                                    update <= 1'b1;
                                end
                            end else begin
                                if (at_left) begin
                                    state <= DROP_R;
                                end else begin
                                    x      <= x - X_W'(STEP);
                                    update <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DROP_L, DROP_R: begin
                    if (kill) begin
                        state  <= DEAD;
                        active <= 1'b0;
                        dead   <= 1'b1;
                    end else if (!freeze) begin
                        y      <= y_drop[Y_W-1:0];
                        update <= 1'b1;
                        period <= period_next;
                        tcnt   <= '0;
                        fcnt   <= '0;
                        dir    <= (state == DROP_R);
                        if (will_land) begin
                            state  <= LANDED;
                            active <= 1'b0;
                            landed <= 1'b1;
                        end else begin
                            state <= (state == DROP_L) ? LEFT : RIGHT;
                        end
                    end
                end
                LANDED, DEAD: begin
                    if (go && !freeze) begin
                        state  <= RIGHT;
                        x      <= X_RST;
                        y      <= Y_RST;
                        dir    <= 1'b1;
                        period <= P_RST;
                        tcnt   <= '0;
                        fcnt   <= '0;
                        update <= (x != X_RST) || (y != Y_RST);
                        active <= 1'b1;
                        landed <= 1'b0;
                        dead   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
